// File: rtl/tablero_pkg.sv
// Shared types and constants for the board store: cell codes, board FSM states
// and rejection reason codes.
package tablero_pkg;

  typedef enum logic [1:0] {
    VACIA    = 2'd0,
    J1       = 2'd1,
    J2       = 2'd2,
    INVALIDA = 2'd3
  } celda_t;

  typedef enum logic [1:0] {
    VACIO   = 2'd0,
    JUGANDO = 2'd1,
    LLENO   = 2'd2
  } estado_t;

  localparam logic [1:0] ERR_OCUPADA = 2'd0;
  localparam logic [1:0] ERR_RANGO   = 2'd1;
  localparam logic [1:0] ERR_TURNO   = 2'd2;
  localparam logic [1:0] ERR_CODIGO  = 2'd3;

endpackage

// File: rtl/fila_completa.sv
// One board row -> "every cell non-empty" flag (OR per cell, AND across the row).
module fila_completa #(
  parameter int N  = 3,
  parameter int CW = 2
) (
  input  logic [N-1:0][CW-1:0] celdas,
  output logic                 llena
);

  always_comb begin
    llena = 1'b1;
    for (int c = 0; c < N; c++) llena = llena & (|celdas[c]);
  end

endmodule

// File: rtl/tablero_ocupacion.sv
// Registered NxN board with a move handshake: validates moves, enforces turn
// order and tracks occupancy, per-row full flags and board-full.
module tablero_ocupacion
  import tablero_pkg::*;
#(
  parameter int N  = 3,
  parameter int CW = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          limpiar,
  input  logic                          mov_valido,
  output logic                          mov_listo,
  input  logic [$clog2(N)-1:0]          mov_fila,
  input  logic [$clog2(N)-1:0]          mov_col,
  input  logic [CW-1:0]                 mov_jugador,
  output logic                          mov_ack,
  output logic                          mov_error,
  output logic [1:0]                    error_cod,
  output logic [N-1:0][N-1:0][CW-1:0]   juego,
  output logic [CW-1:0]                 turno,
  output logic [$clog2(N*N+1)-1:0]      ocupadas,
  output logic [N-1:0]                  fila_llena,
  output logic                          lleno
);

  localparam int FW = $clog2(N);
  localparam int OW = $clog2(N*N+1);
  // One extra bit so the range check also works when N is a power of two.
  localparam logic [FW:0]   N_L   = (FW+1)'(N);
  localparam logic [OW-1:0] TOTAL = OW'(N*N);

  estado_t                       estado_q, estado_d;
  logic [N-1:0][N-1:0][CW-1:0]   juego_q, juego_d;
  logic [CW-1:0]                 turno_q, turno_d;
  logic [OW-1:0]                 ocupadas_q, ocupadas_d;
  logic                          ack_q, ack_d;
  logic                          err_q, err_d;
  logic [1:0]                    error_cod_q, error_cod_d;

  logic fuera, codigo_malo, turno_malo, ocupada;

  always_comb begin
    fuera       = ({1'b0, mov_fila} >= N_L) || ({1'b0, mov_col} >= N_L);
    codigo_malo = (mov_jugador == CW'(VACIA)) || (mov_jugador > CW'(J2));
    turno_malo  = (mov_jugador != turno_q);
    ocupada     = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (mov_fila == FW'(r) && mov_col == FW'(c) && juego_q[r][c] != '0)
          ocupada = 1'b1;
  end

  always_comb begin
    estado_d    = estado_q;
    juego_d     = juego_q;
    turno_d     = turno_q;
    ocupadas_d  = ocupadas_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    error_cod_d = error_cod_q;
    if (limpiar) begin
      // Clear wins over a simultaneous move, which is dropped silently.
      estado_d    = VACIO;
      juego_d     = '0;
      turno_d     = CW'(J1);
      ocupadas_d  = '0;
      error_cod_d = ERR_OCUPADA;
    end else if (mov_valido && estado_q != LLENO) begin
      if (fuera) begin
        err_d = 1'b1; error_cod_d = ERR_RANGO;
      end else if (codigo_malo) begin
        err_d = 1'b1; error_cod_d = ERR_CODIGO;
      end else if (turno_malo) begin
        err_d = 1'b1; error_cod_d = ERR_TURNO;
      end else if (ocupada) begin
        err_d = 1'b1; error_cod_d = ERR_OCUPADA;
      end else begin
        ack_d = 1'b1;
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++)
            if (mov_fila == FW'(r) && mov_col == FW'(c)) juego_d[r][c] = mov_jugador;
        ocupadas_d = ocupadas_q + OW'(1);
        turno_d    = (turno_q == CW'(J1)) ? CW'(J2) : CW'(J1);
        estado_d   = (ocupadas_q + OW'(1) == TOTAL) ? LLENO : JUGANDO;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q    <= VACIO;
      juego_q     <= '0;
      turno_q     <= CW'(J1);
      ocupadas_q  <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      error_cod_q <= ERR_OCUPADA;
    end else begin
      estado_q    <= estado_d;
      juego_q     <= juego_d;
      turno_q     <= turno_d;
      ocupadas_q  <= ocupadas_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      error_cod_q <= error_cod_d;
    end
  end

  for (genvar gr = 0; gr < N; gr++) begin : g_fila
    fila_completa #(.N(N), .CW(CW)) u_fila (
      .celdas (juego_q[gr]),
      .llena  (fila_llena[gr])
    );
  end

  assign mov_listo = (estado_q != LLENO);
  assign mov_ack   = ack_q;
  assign mov_error = err_q;
  assign error_cod = error_cod_q;
  assign juego     = juego_q;
  assign turno     = turno_q;
  assign ocupadas  = ocupadas_q;
  // Full flag comes from the counter, independent of the row flags.
  assign lleno     = (ocupadas_q == TOTAL);

endmodule

// File: tb/tb_tablero_ocupacion.sv
// Bench for tablero_ocupacion: N=3 and N=4 instances driven from shared move
// inputs, checked against an array-based board model.
module tb_tablero_ocupacion;

  logic clk = 1'b0;
  logic rst_n, limpiar, v3, v4;
  logic [1:0] fila, col, jug;

  logic listo3, ack3, err3, lleno3;
  logic [1:0] ecod3, turno3;
  logic [2:0][2:0][1:0] juego3;
  logic [3:0] ocup3;
  logic [2:0] fl3;

  logic listo4, ack4, err4, lleno4;
  logic [1:0] ecod4, turno4;
  logic [3:0][3:0][1:0] juego4;
  logic [4:0] ocup4;
  logic [3:0] fl4;

  tablero_ocupacion #(.N(3), .CW(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .limpiar(limpiar), .mov_valido(v3), .mov_listo(listo3),
    .mov_fila(fila), .mov_col(col), .mov_jugador(jug), .mov_ack(ack3), .mov_error(err3),
    .error_cod(ecod3), .juego(juego3), .turno(turno3), .ocupadas(ocup3),
    .fila_llena(fl3), .lleno(lleno3));

  tablero_ocupacion #(.N(4), .CW(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .limpiar(limpiar), .mov_valido(v4), .mov_listo(listo4),
    .mov_fila(fila), .mov_col(col), .mov_jugador(jug), .mov_ack(ack4), .mov_error(err4),
    .error_cod(ecod4), .juego(juego4), .turno(turno4), .ocupadas(ocup4),
    .fila_llena(fl4), .lleno(lleno4));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int bd[2][8][8];
  int turn[2];
  int ecod[2];

  function automatic int nn(input int k);
    return (k == 0) ? 3 : 4;
  endfunction

  function automatic int cnt(input int k);
    int s = 0;
    for (int r = 0; r < nn(k); r++)
      for (int c = 0; c < nn(k); c++)
        if (bd[k][r][c] != 0) s++;
    return s;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) bd[k][r][c] = 0;
      turn[k] = 1;
      ecod[k] = 0;
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, nn(k), obs, exp);
    end
  endtask

  task automatic check_all(input int k, input int eack, input int eerr);
    int n = nn(k);
    int occ = cnt(k);
    logic [63:0] eb, ob, efl, ofl;
    logic oack, oerr, olleno, olisto, all_rows;
    logic [1:0] oecod, oturno;
    logic [63:0] oocc;
    eb = '0; ob = '0; efl = '0; ofl = '0; oocc = '0;
    for (int r = 0; r < n; r++) begin
      efl[r] = 1'b1;
      for (int c = 0; c < n; c++) begin
        eb[(r*n+c)*2 +: 2] = 2'(bd[k][r][c]);
        if (bd[k][r][c] == 0) efl[r] = 1'b0;
      end
    end
    if (k == 0) begin
      oack = ack3; oerr = err3; oecod = ecod3; oturno = turno3; olleno = lleno3;
      olisto = listo3; ob[17:0] = juego3; oocc[3:0] = ocup3; ofl[2:0] = fl3;
    end else begin
      oack = ack4; oerr = err4; oecod = ecod4; oturno = turno4; olleno = lleno4;
      olisto = listo4; ob[31:0] = juego4; oocc[4:0] = ocup4; ofl[3:0] = fl4;
    end
    all_rows = 1'b1;
    for (int r = 0; r < n; r++) all_rows = all_rows & ofl[r];
    chk("ack",        k, 64'(oack),   64'(eack));
    chk("error",      k, 64'(oerr),   64'(eerr));
    chk("error_cod",  k, 64'(oecod),  64'(ecod[k]));
    chk("juego",      k, ob,          eb);
    chk("turno",      k, 64'(oturno), 64'(turn[k]));
    chk("ocupadas",   k, oocc,        64'(occ));
    chk("fila_llena", k, ofl,         efl);
    chk("lleno",      k, 64'(olleno), 64'(occ == n*n));
    chk("mov_listo",  k, 64'(olisto), 64'(occ != n*n));
    chk("lleno_vs_filas", k, 64'(olleno), 64'(all_rows));
  endtask

  // Called at a falling edge; presents one move for one edge, then checks.
  task automatic do_move(input int k, input int f, input int c, input int p, input bit clr);
    int n = nn(k);
    int eack = 0, eerr = 0;
    fila = 2'(f); col = 2'(c); jug = 2'(p);
    v3 = (k == 0); v4 = (k == 1); limpiar = clr;
    if (clr) model_clear();
    else if (cnt(k) != n*n) begin
      if (f >= n || c >= n)         begin eerr = 1; ecod[k] = 1; end
      else if (p == 0 || p == 3)    begin eerr = 1; ecod[k] = 3; end
      else if (p != turn[k])        begin eerr = 1; ecod[k] = 2; end
      else if (bd[k][f][c] != 0)    begin eerr = 1; ecod[k] = 0; end
      else begin bd[k][f][c] = p; turn[k] = 3 - turn[k]; eack = 1; end
    end
    @(posedge clk);
    @(negedge clk);
    v3 = 1'b0; v4 = 1'b0; limpiar = 1'b0;
    check_all(k, eack, eerr);
    if (clr) check_all(1 - k, 0, 0);
  endtask

  task automatic fill_legal(input int k, input int limit);
    int done = 0;
    for (int r = 0; r < nn(k); r++)
      for (int c = 0; c < nn(k); c++)
        if (bd[k][r][c] == 0 && done < limit) begin
          do_move(k, r, c, turn[k], 1'b0);
          done++;
        end
  endtask

  initial begin
    rst_n = 1'b0; limpiar = 1'b0; v3 = 1'b0; v4 = 1'b0;
    fila = '0; col = '0; jug = '0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all(0, 0, 0);
    check_all(1, 0, 0);

    do_move(0, 0, 0, 1, 0);
    do_move(0, 1, 1, 2, 0);
    do_move(0, 0, 1, 1, 0);
    do_move(0, 0, 2, 2, 0);
    chk("occ_after_4", 0, 64'(ocup3), 64'd4);
    chk("rows_after_4", 0, 64'(fl3), 64'b001);

    do_move(0, 1, 1, 1, 0);
    do_move(0, 2, 2, 2, 0);
    chk("wrong_turn_code", 0, 64'(ecod3), 64'd2);
    do_move(0, 3, 0, 1, 0);
    do_move(0, 2, 2, 3, 0);
    chk("illegal_code", 0, 64'(ecod3), 64'd3);

    fill_legal(0, 9);
    chk("full_lleno", 0, 64'(lleno3), 64'd1);
    chk("full_listo", 0, 64'(listo3), 64'd0);
    do_move(0, 0, 0, 1, 0);
    do_move(0, 0, 0, 1, 1);
    chk("clear_occ", 0, 64'(ocup3), 64'd0);

    do_move(0, 2, 1, 1, 0);
    do_move(1, 3, 3, 1, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 model_clear();
    check_all(0, 0, 0);
    check_all(1, 0, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    fill_legal(1, 15);
    chk("n4_15_lleno", 1, 64'(lleno4), 64'd0);
    fill_legal(1, 1);
    chk("n4_16_occ", 1, 64'(ocup4), 64'd16);
    chk("n4_16_lleno", 1, 64'(lleno4), 64'd1);
    do_move(1, 0, 0, 1, 1);

    for (int i = 0; i < 400; i++) begin
      int k = int'($urandom_range(1, 0));
      int p = ($urandom_range(9, 0) < 7) ? turn[k] : int'($urandom_range(3, 0));
      do_move(k, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), p,
              $urandom_range(39, 0) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
